// File: rtl/i2s_tx_core.sv
// Philips-format I2S master transmitter: 64 SCK per frame, 32-bit slots, MSB first.
// One-entry holding register feeds the shift register at every slot boundary.
module i2s_tx_core #(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  aud_clk_i,
  input  logic                  aud_rst_i,
  input  logic                  en_i,
  input  logic [DIV_WIDTH-1:0]  div_i,
  input  logic [1:0]            wlen_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  sck_o,
  output logic                  ws_o,
  output logic                  sd_o,
  output logic                  busy_o,
  output logic                  udr_o
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [1:0]            wlen_q, wlen_d;
  logic [5:0]            bcnt_q, bcnt_d;
  logic                  sck_q, sck_d;
  logic                  ws_q, ws_d;
  logic                  sd_q, sd_d;
  logic                  udr_q, udr_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;

  logic                  accept;
  logic                  load;
  logic [5:0]            nb;
  logic [1:0]            eff_wlen;
  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] sh_src;

  // Prefill in IDLE uses the live word length; in RUN the latched one.
  assign eff_wlen = (state_q == RUN) ? wlen_q : wlen_i;
  assign shamt    = {~eff_wlen, 3'b000};
  assign accept   = valid_i & ~hold_full_q;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    wlen_d      = wlen_q;
    bcnt_d      = bcnt_q;
    sck_d       = sck_q;
    ws_d        = ws_q;
    sd_d        = sd_q;
    udr_d       = 1'b0;
    sh_d        = sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load        = 1'b0;
    nb          = bcnt_q + 6'd1;
    sh_src      = sh_q;

    case (state_q)
      IDLE: begin
        sck_d = 1'b0;
        ws_d  = 1'b0;
        sd_d  = 1'b0;
        if (en_i) begin
          state_d = RUN;
          div_d   = div_i;
          wlen_d  = wlen_i;
          cnt_d   = '0;
          bcnt_d  = 6'd63;
        end
      end
      RUN: begin
        if (cnt_q == div_q) begin
          cnt_d = '0;
          sck_d = ~sck_q;
          if (sck_q) begin
            // Disable only takes effect at the frame wrap so frames are never cut short.
            if ((bcnt_q == 6'd63) && !en_i) begin
              state_d = IDLE;
              ws_d    = 1'b0;
              sd_d    = 1'b0;
            end else begin
              bcnt_d = nb;
              if (nb[4:0] == 5'd0) begin
                load   = 1'b1;
                sh_src = hold_full_q ? hold_q : '0;
                udr_d  = ~hold_full_q;
              end
              sd_d = sh_src[DATA_WIDTH-1];
              sh_d = sh_src << 1;
              ws_d = (nb >= 6'd31) && (nb <= 6'd62);
            end
          end
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (load)
      hold_full_d = 1'b0;
    if (accept) begin
      hold_d      = data_i << shamt;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge aud_clk_i or posedge aud_rst_i) begin
    if (aud_rst_i) begin
      state_q     <= IDLE;
      div_q       <= '0;
      cnt_q       <= '0;
      wlen_q      <= 2'd3;
      bcnt_q      <= 6'd63;
      sck_q       <= 1'b0;
      ws_q        <= 1'b0;
      sd_q        <= 1'b0;
      udr_q       <= 1'b0;
      sh_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      wlen_q      <= wlen_d;
      bcnt_q      <= bcnt_d;
      sck_q       <= sck_d;
      ws_q        <= ws_d;
      sd_q        <= sd_d;
      udr_q       <= udr_d;
      sh_q        <= sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  assign ready_o = ~hold_full_q;
  assign sck_o   = sck_q;
  assign ws_o    = ws_q;
  assign sd_o    = sd_q;
  assign udr_o   = udr_q;
  assign busy_o  = (state_q == RUN);

endmodule

// File: tb/tb_i2s_tx_core.sv
// Bench for i2s_tx_core: expected slot words queued at accept, popped by a serial-line monitor.
module tb_i2s_tx_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  div = 8'd0;
  logic [1:0]  wlen = 2'd3;
  logic [31:0] data = 32'd0;
  logic        ready, sck, ws, sd, busy, udr;

  always #5 clk = ~clk;

  i2s_tx_core #(.DATA_WIDTH(32), .DIV_WIDTH(8)) dut (
    .aud_clk_i(clk), .aud_rst_i(rst), .en_i(en), .div_i(div), .wlen_i(wlen),
    .data_i(data), .valid_i(valid), .ready_o(ready), .sck_o(sck), .ws_o(ws),
    .sd_o(sd), .busy_o(busy), .udr_o(udr)
  );

  typedef struct { logic ch; logic [31:0] w; } exp_t;
  exp_t exp_q[$];

  int   checks = 0;
  int   errors = 0;
  logic next_ch = 1'b0;

  logic [5:0]  mbcnt = 6'd63;
  int          nbits = 0;
  logic [31:0] acc = 32'd0;
  logic        ws_first = 1'b0;
  logic        prev_sck = 1'b0, prev_ws = 1'b0, prev_sd = 1'b0;
  int          frames = 0;
  int          udr_cnt = 0;

  // Serial-side monitor: rebuilds slot position from SCK falls and assembles words on SCK rises.
  always @(negedge clk) begin : mon
    logic        fall, rise;
    logic [31:0] expw;
    exp_t        e;
    fall = prev_sck & ~sck;
    rise = ~prev_sck & sck;
    if (!busy) begin
      mbcnt = 6'd63;
      nbits = 0;
    end else begin
      if (fall) begin
        mbcnt = mbcnt + 6'd1;
        if (mbcnt == 6'd0) frames++;
      end
      if (rise) begin
        if (mbcnt[4:0] == 5'd0) begin
          acc = {31'd0, sd};
          nbits = 1;
          ws_first = ws;
        end else begin
          acc = {acc[30:0], sd};
          nbits++;
        end
        if (mbcnt[4:0] == 5'd31 && nbits == 32) begin
          expw = 32'd0;
          if (exp_q.size() > 0 && exp_q[0].ch == mbcnt[5]) begin
            e = exp_q.pop_front();
            expw = e.w;
          end
          checks++;
          if (acc !== expw) begin
            errors++;
            $display("FAIL slot_word ch=%0d got %h expected %h", mbcnt[5], acc, expw);
          end
          checks++;
          if (ws_first !== mbcnt[5] || ws !== ~mbcnt[5]) begin
            errors++;
            $display("FAIL ws_align ch=%0d ws_msb=%0b ws_lsb=%0b", mbcnt[5], ws_first, ws);
          end
        end
      end
    end
    if (udr) begin
      udr_cnt++;
      checks++;
      if (!(fall && busy && mbcnt[4:0] == 5'd0)) begin
        errors++;
        $display("FAIL udr_timing fall=%0b bcnt=%0d expected fall at slot start", fall, mbcnt);
      end
    end
    if (!rst && !fall && (ws !== prev_ws || sd !== prev_sd)) begin
      checks++;
      errors++;
      $display("FAIL out_stable ws/sd changed without SCK fall ws=%0b sd=%0b", ws, sd);
    end
    prev_sck = sck;
    prev_ws  = ws;
    prev_sd  = sd;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic add_exp(input logic [31:0] d, input logic [1:0] wl);
    exp_t e;
    case (wl)
      2'd0:    e.w = {d[7:0], 24'd0};
      2'd1:    e.w = {d[15:0], 16'd0};
      2'd2:    e.w = {d[23:0], 8'd0};
      default: e.w = d;
    endcase
    e.ch = next_ch;
    next_ch = ~next_ch;
    exp_q.push_back(e);
  endtask

  task automatic push_word(input logic [31:0] d, input logic [1:0] wl);
    int t = 0;
    while (!ready && t < 5000) begin tick(); t++; end
    checks++;
    if (!ready) begin
      errors++;
      $display("FAIL push_timeout ready stayed 0 expected 1");
      return;
    end
    valid = 1'b1;
    data  = d;
    tick();
    valid = 1'b0;
    add_exp(d, wl);
  endtask

  task automatic wait_q_empty();
    int t = 0;
    while (exp_q.size() != 0 && t < 8000) begin tick(); t++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d expected 0", exp_q.size());
    end
  endtask

  task automatic wait_mbcnt(input logic [5:0] v);
    int t = 0;
    while (!(busy && mbcnt == v) && t < 8000) begin tick(); t++; end
    checks++;
    if (mbcnt != v) begin
      errors++;
      $display("FAIL bcnt_timeout got %0d expected %0d", mbcnt, v);
    end
  endtask

  task automatic wait_frames(input int target);
    int t = 0;
    while (frames < target && t < 8000) begin tick(); t++; end
    checks++;
    if (frames < target) begin
      errors++;
      $display("FAIL frame_timeout got %0d expected %0d", frames, target);
    end
  endtask

  task automatic stop_tx();
    int t = 0;
    en = 1'b0;
    while (busy && t < 8000) begin tick(); t++; end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_timeout busy=%0b expected 0", busy);
    end
    tick();
  endtask

  // Enables and records sample indices (cycles after RUN entry) of first SCK rise, fall, rise.
  task automatic start_measure(output int t_r, output int t_f, output int t_r2);
    int t = 0;
    int n = 0;
    t_r = -1; t_f = -1; t_r2 = -1;
    en = 1'b1;
    tick();
    while (!busy && t < 100) begin tick(); t++; end
    while (t_r2 < 0 && n < 2000) begin
      tick();
      n++;
      if (t_r < 0 && sck) t_r = n;
      else if (t_r >= 0 && t_f < 0 && !sck) t_f = n;
      else if (t_f >= 0 && t_r2 < 0 && sck) t_r2 = n;
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks += 6;
    if (sck !== 1'b0)   begin errors++; $display("FAIL reset_sck got %0b expected 0", sck); end
    if (ws !== 1'b0)    begin errors++; $display("FAIL reset_ws got %0b expected 0", ws); end
    if (sd !== 1'b0)    begin errors++; $display("FAIL reset_sd got %0b expected 0", sd); end
    if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %0b expected 0", busy); end
    if (udr !== 1'b0)   begin errors++; $display("FAIL reset_udr got %0b expected 0", udr); end
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b expected 1", ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int tr, tf, tr2;
    next_ch = 1'b0;
    div = 8'd1;
    wlen = 2'd3;
    push_word(32'hA5A5_0F0F, 2'd3);
    start_measure(tr, tf, tr2);
    checks += 3;
    if (tr != 2)       begin errors++; $display("FAIL basic_first_rise got %0d expected 2", tr); end
    if (tf != 4)       begin errors++; $display("FAIL basic_first_fall got %0d expected 4", tf); end
    if (tr2 - tr != 4) begin errors++; $display("FAIL basic_sck_period got %0d expected 4", tr2 - tr); end
    push_word(32'h1234_5678, 2'd3);
    wait_q_empty();
    stop_tx();
  endtask

  task automatic test_wlen();
    next_ch = 1'b0;
    div = 8'd0;
    wlen = 2'd1;
    push_word(32'h0000_BEEF, 2'd1);
    en = 1'b1;
    wait_q_empty();
    stop_tx();
    wlen = 2'd3;
  endtask

  task automatic test_underflow();
    int f0, u0, u1;
    next_ch = 1'b0;
    div = 8'd0;
    wlen = 2'd3;
    f0 = frames;
    en = 1'b1;
    wait_frames(f0 + 1);
    u0 = udr_cnt;
    wait_frames(f0 + 3);
    u1 = udr_cnt;
    checks++;
    if (u1 - u0 != 4) begin errors++; $display("FAIL udr_count got %0d expected 4", u1 - u0); end
    wait_mbcnt(6'd40);
    push_word(32'hDEAD_BEEF, 2'd3);
    wait_q_empty();
    stop_tx();
  endtask

  task automatic test_disable();
    next_ch = 1'b0;
    div = 8'd0;
    wlen = 2'd3;
    push_word(32'h1111_2222, 2'd3);
    en = 1'b1;
    push_word(32'h3333_4444, 2'd3);
    wait_mbcnt(6'd10);
    en = 1'b0;
    push_word(32'h5555_6666, 2'd3);
    stop_tx();
    checks += 6;
    if (busy !== 1'b0)      begin errors++; $display("FAIL dis_busy got %0b expected 0", busy); end
    if (sck !== 1'b0)       begin errors++; $display("FAIL dis_sck got %0b expected 0", sck); end
    if (ws !== 1'b0)        begin errors++; $display("FAIL dis_ws got %0b expected 0", ws); end
    if (sd !== 1'b0)        begin errors++; $display("FAIL dis_sd got %0b expected 0", sd); end
    if (ready !== 1'b0)     begin errors++; $display("FAIL dis_hold_kept ready=%0b expected 0", ready); end
    if (exp_q.size() != 1)  begin errors++; $display("FAIL dis_pending got %0d expected 1", exp_q.size()); end
    en = 1'b1;
    wait_q_empty();
    stop_tx();
  endtask

  task automatic test_back_to_back();
    int f0, cnt, t;
    logic acc_ok;
    next_ch = 1'b0;
    div = 8'd1;
    wlen = 2'd3;
    cnt = 0;
    t = 0;
    f0 = frames;
    valid = 1'b1;
    data = 32'hC000_0000;
    acc_ok = ready;
    en = 1'b1;
    while (t < 5000) begin
      tick();
      t++;
      if (acc_ok) begin add_exp(data, 2'd3); cnt++; end
      if (frames - f0 >= 3) break;
      data = 32'hC000_0000 + 32'(cnt);
      acc_ok = ready;
    end
    valid = 1'b0;
    checks++;
    if (cnt != 5) begin errors++; $display("FAIL b2b_accepts got %0d expected 5", cnt); end
    wait_q_empty();
    stop_tx();
  endtask

  task automatic test_reset_midframe();
    int tr, tf, tr2;
    next_ch = 1'b0;
    div = 8'd2;
    wlen = 2'd3;
    push_word(32'h0BAD_F00D, 2'd3);
    en = 1'b1;
    push_word(32'h7777_8888, 2'd3);
    wait_mbcnt(6'd40);
    push_word(32'h9999_AAAA, 2'd3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks += 6;
    if (sck !== 1'b0)   begin errors++; $display("FAIL rstmid_sck got %0b expected 0", sck); end
    if (ws !== 1'b0)    begin errors++; $display("FAIL rstmid_ws got %0b expected 0", ws); end
    if (sd !== 1'b0)    begin errors++; $display("FAIL rstmid_sd got %0b expected 0", sd); end
    if (busy !== 1'b0)  begin errors++; $display("FAIL rstmid_busy got %0b expected 0", busy); end
    if (udr !== 1'b0)   begin errors++; $display("FAIL rstmid_udr got %0b expected 0", udr); end
    if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %0b expected 1", ready); end
    exp_q.delete();
    en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    next_ch = 1'b0;
    push_word(32'hCAFE_F00D, 2'd3);
    start_measure(tr, tf, tr2);
    checks += 2;
    if (tr != 3) begin errors++; $display("FAIL rstmid_first_rise got %0d expected 3", tr); end
    if (tf != 6) begin errors++; $display("FAIL rstmid_first_fall got %0d expected 6", tf); end
    wait_q_empty();
    stop_tx();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wlen();
    test_underflow();
    test_disable();
    test_back_to_back();
    test_reset_midframe();
    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_tx_core.md
# i2s_tx_core

Audio-domain I2S transmitter core that drives the serial side of the I2S peripheral. It sits downstream of the audio-domain TX sample FIFO and upstream of the `i2s` interface pins. It pulls stereo words over a valid/ready handshake, generates SCK and WS in master mode, and shifts data out MSB-first in Philips format (64 SCK per frame, 32-bit slots). Word order on the handshake is strictly left, right, left, and so on.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of `data_i` and the slot width; fixed at 32 for this block.
- `DIV_WIDTH`, 8: width of the SCK divider input.

Ports:
- Clock and reset: one clock (`aud_clk_i`); reset is asynchronous and active-high (`aud_rst_i`).
- `aud_clk_i`  in  1  audio clock; all logic is on its rising edge.
- `aud_rst_i`  in  1  asynchronous, active-high reset.
- `en_i`  in  1  transmit enable.
- `div_i`  in  DIV_WIDTH  SCK half-period minus one, in `aud_clk_i` cycles.
- `wlen_i`  in  2  word length: 0=8, 1=16, 2=24, 3=32 bits.
- `data_i`  in  32  sample, right-aligned to `wlen_i`.
- `valid_i`  in  1  `data_i` is valid.
- `ready_o`  out  1  holding register is empty.
- `sck_o`  out  1  serial clock.
- `ws_o`  out  1  word select: 0=left, 1=right.
- `sd_o`  out  1  serial data.
- `busy_o`  out  1  FSM is in RUN.
- `udr_o`  out  1  one-cycle pulse on underflow.

## Operation
- Holding register: one entry. `ready_o = ~hold_full`, which is combinational. A word is accepted when `valid_i & ready_o`.
- Word conversion on accept: `data_i` is stored left-justified as `data_i << (32 - wlen_bits)`. Bits below the word length are zero.
- Prefill: accepting is allowed in IDLE.
- FSM states:
  - IDLE: `sck_o`, `ws_o`, `sd_o` are all 0 and `busy_o` is 0. When `en_i`=1, latch `div_i` and `wlen_i`, set divider=0 and `bcnt`=63, and go to RUN.
  - RUN: the divider counts 0..div. At terminal count, `sck_o` toggles and the divider reloads to 0.
- Falling edge: `sck_o` going 1→0 is the bit boundary. On each one:
  - `bcnt` ← `bcnt`+1, wrapping 63→0.
  - If the new `bcnt` mod 32 == 0, load the shift register from the holding register and clear `hold_full`. If `hold_full`=0, load 0 and pulse `udr_o`.
  - `sd_o` ← MSB of the (newly loaded or current) shift register; the shift register then shifts left by 1.
  - `ws_o` ← 1 if the new `bcnt` is in 31..62, else 0. WS therefore leads the MSB by one SCK.
- Channel order: slot `bcnt` 0..31 is left and 32..63 is right. Underflow still consumes a slot, so left/right alignment is never lost.
- Disable: `en_i`=0 is honoured only at the falling edge where `bcnt` wraps 63→0. At that edge no load occurs, the FSM goes to IDLE, and the outputs return to 0.
  - Holding register contents are preserved.
  - Re-enable restarts a fresh frame with left first.
- Config stability: `div_i` and `wlen_i` are ignored while in RUN. Changing them requires disable and re-enable.
- Simultaneous load and accept in the same cycle: the holding register loads into the shift register and the new word is written into it. `hold_full` stays 1.

## Timing
- Reset values:
  - `sck_o`=0, `ws_o`=0, `sd_o`=0, `busy_o`=0, `udr_o`=0.
  - `ready_o`=1, because `hold_full`=0.
  - Internal: `bcnt`=63, divider=0.
- SCK period is 2·(div+1) cycles. Frame length is 128·(div+1) cycles.
- SCK rises (div+1) cycles after RUN entry. The first falling edge comes 2·(div+1) cycles after RUN entry; it sets `bcnt`=0 and `sd_o` = left MSB.
- `sd_o` and `ws_o` change only in the same cycle `sck_o` falls, so they are stable across the rising edge.
- `udr_o` is high for exactly one `aud_clk_i` cycle, coincident with the falling edge.
- `ready_o` rises in the cycle after a load.
- Asynchronous reset in mid-frame: all outputs go to reset values immediately and the holding register is emptied.
- div=0 is legal: SCK = `aud_clk_i`/2.

## Test plan
- Basic stereo: div=1, wlen=3, push L=0xA5A5_0F0F then R=0x1234_5678, en=1.
  - `sd_o` sampled on SCK rise gives A5A50F0F then 12345678, MSB first.
  - `ws_o` rises one SCK before R's MSB.
  - SCK period is 4 cycles.
- Word length: wlen=1, push L=0x0000_BEEF.
  - Left slot bits read 0xBEEF followed by 16 zeros.
- Underflow: en=1 with the FIFO empty.
  - `udr_o` pulses at `bcnt`=0 and 32 of each frame, and `sd_o`=0 throughout.
  - Push a word mid-right-slot: it appears in the next left slot.
- Disable mid-frame: deassert `en_i` at `bcnt`=10.
  - The frame completes through `bcnt`=63, then `busy_o`=0, `sck_o`=0, `ws_o`=0.
  - A buffered word survives and is sent as left after re-enable.
- Backpressure: hold `valid_i`=1 with a counting pattern.
  - `ready_o` accepts exactly one word per slot, and words appear on `sd_o` in order with no loss.
- Reset in mid-frame: assert `aud_rst_i` during the right slot.
  - Outputs clear immediately and `ready_o`=1.
  - After release and en=1, the first SCK fall is at 2·(div+1) cycles with a left word.
